// File: rtl/sin_lut.sv
// Phase-to-amplitude converter for the DDFS: quarter-wave ROM with quadrant folding,
// three-stage pipeline (fold address, ROM read, sign apply) with a valid flag.
module sin_lut #(
    parameter int NBIT = 12,
    parameter int DBIT = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBIT-1:0] phase_in,
    input  logic            phase_valid,
    output logic [DBIT-1:0] sin_out,
    output logic            sin_valid
);

    logic [7:0]      phase_top;
    logic [5:0]      addr_d;
    logic [5:0]      addr_q;
    logic            sign1_q;
    logic            v1_q;
    logic [10:0]     rom_mag;
    logic [10:0]     mag_q;
    logic            sign2_q;
    logic            v2_q;
    logic [DBIT-1:0] mag_ext;
    logic [DBIT-1:0] sin_d;
    logic [DBIT-1:0] sin_q;
    logic            sin_valid_q;

    assign phase_top = phase_in[NBIT-1 -: 8];

    // Low phase bits are truncated away without dither.
    generate
        if (NBIT > 8) begin : g_trunc
            logic phase_lsb_unused;
            assign phase_lsb_unused = ^phase_in[NBIT-9:0];
        end
    endgenerate

    // Odd quadrants read the quarter wave backwards.
    assign addr_d = phase_top[6] ? ~phase_top[5:0] : phase_top[5:0];

    always_comb begin
        rom_mag = 11'd0;
        case (addr_q)
            6'd0:  rom_mag = 11'd25;
            6'd1:  rom_mag = 11'd75;
            6'd2:  rom_mag = 11'd126;
            6'd3:  rom_mag = 11'd176;
            6'd4:  rom_mag = 11'd226;
            6'd5:  rom_mag = 11'd275;
            6'd6:  rom_mag = 11'd325;
            6'd7:  rom_mag = 11'd375;
            6'd8:  rom_mag = 11'd424;
            6'd9:  rom_mag = 11'd473;
            6'd10: rom_mag = 11'd522;
            6'd11: rom_mag = 11'd570;
            6'd12: rom_mag = 11'd618;
            6'd13: rom_mag = 11'd666;
            6'd14: rom_mag = 11'd713;
            6'd15: rom_mag = 11'd760;
            6'd16: rom_mag = 11'd807;
            6'd17: rom_mag = 11'd852;
            6'd18: rom_mag = 11'd898;
            6'd19: rom_mag = 11'd943;
            6'd20: rom_mag = 11'd987;
            6'd21: rom_mag = 11'd1031;
            6'd22: rom_mag = 11'd1074;
            6'd23: rom_mag = 11'd1116;
            6'd24: rom_mag = 11'd1158;
            6'd25: rom_mag = 11'd1199;
            6'd26: rom_mag = 11'd1239;
            6'd27: rom_mag = 11'd1279;
            6'd28: rom_mag = 11'd1318;
            6'd29: rom_mag = 11'd1356;
            6'd30: rom_mag = 11'd1393;
            6'd31: rom_mag = 11'd1430;
            6'd32: rom_mag = 11'd1465;
            6'd33: rom_mag = 11'd1500;
            6'd34: rom_mag = 11'd1533;
            6'd35: rom_mag = 11'd1566;
            6'd36: rom_mag = 11'd1598;
            6'd37: rom_mag = 11'd1629;
            6'd38: rom_mag = 11'd1659;
            6'd39: rom_mag = 11'd1688;
            6'd40: rom_mag = 11'd1716;
            6'd41: rom_mag = 11'd1743;
            6'd42: rom_mag = 11'd1769;
            6'd43: rom_mag = 11'd1793;
            6'd44: rom_mag = 11'd1817;
            6'd45: rom_mag = 11'd1840;
            6'd46: rom_mag = 11'd1861;
            6'd47: rom_mag = 11'd1881;
            6'd48: rom_mag = 11'd1901;
            6'd49: rom_mag = 11'd1919;
            6'd50: rom_mag = 11'd1936;
            6'd51: rom_mag = 11'd1951;
            6'd52: rom_mag = 11'd1966;
            6'd53: rom_mag = 11'd1979;
            6'd54: rom_mag = 11'd1992;
            6'd55: rom_mag = 11'd2003;
            6'd56: rom_mag = 11'd2012;
            6'd57: rom_mag = 11'd2021;
            6'd58: rom_mag = 11'd2028;
            6'd59: rom_mag = 11'd2035;
            6'd60: rom_mag = 11'd2039;
            6'd61: rom_mag = 11'd2043;
            6'd62: rom_mag = 11'd2046;
            6'd63: rom_mag = 11'd2047;
            default: rom_mag = 11'd0;
        endcase
    end

    // Magnitude never exceeds 2047, so negation cannot reach -2048.
    assign mag_ext = {{(DBIT-11){1'b0}}, mag_q};
    assign sin_d   = sign2_q ? (~mag_ext + 1'b1) : mag_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            sign1_q     <= 1'b0;
            v1_q        <= 1'b0;
            mag_q       <= '0;
            sign2_q     <= 1'b0;
            v2_q        <= 1'b0;
            sin_q       <= '0;
            sin_valid_q <= 1'b0;
        end else begin
            v1_q        <= phase_valid;
            v2_q        <= v1_q;
            sin_valid_q <= v2_q;
            if (phase_valid) begin
                addr_q  <= addr_d;
                sign1_q <= phase_top[7];
            end
            if (v1_q) begin
                mag_q   <= rom_mag;
                sign2_q <= sign1_q;
            end
            if (v2_q) begin
                sin_q <= sin_d;
            end
        end
    end

    assign sin_out   = sin_q;
    assign sin_valid = sin_valid_q;

endmodule
